// File: rtl/miner_pkg.sv
// Shared widths, result record and serializer FSM states for the miner result path.
package miner_pkg;

  localparam int unsigned NONCE_W     = 32;
  localparam int unsigned HASH_W      = 256;
  localparam int unsigned FRAME_BYTES = (NONCE_W + HASH_W) / 8;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
  } result_t;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

endpackage

// File: rtl/byte_shifter.sv
// Loadable left-shift register that presents its top byte, with a byte index
// that flags the terminal byte of the frame.
module byte_shifter #(
  parameter int unsigned WIDTH  = 288,
  parameter int unsigned NBYTES = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [7:0]       top_byte,
  output logic             last
);

  localparam int unsigned IdxW = $clog2(NBYTES);

  logic [WIDTH-1:0] sreg_q;
  logic [IdxW-1:0]  idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      sreg_q <= load_data;
      idx_q  <= '0;
    end else if (shift) begin
      sreg_q <= {sreg_q[WIDTH-9:0], 8'h00};
      idx_q  <= last ? '0 : idx_q + IdxW'(1);
    end
  end

  assign top_byte = sreg_q[WIDTH-1 -: 8];
  assign last     = (idx_q == IdxW'(NBYTES - 1));

endmodule

// File: rtl/result_serializer.sv
// Captures the golden nonce and hash on a rising done and streams them out as a
// byte frame. Define RESULT_CSUM_EN to append an XOR checksum byte to each frame.
module result_serializer #(
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned HASH_W  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic [NONCE_W-1:0] golden_nonce,
  input  logic [HASH_W-1:0]  hashed,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               overflow,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned FRAME_BYTES = (NONCE_W + HASH_W) / 8;
`ifdef RESULT_CSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_BYTES + 1;
`else
  localparam int unsigned FRAME_LEN = FRAME_BYTES;
`endif

  import miner_pkg::*;

  ser_state_e  state_q, state_d;
  logic        done_q;
  logic        rise;
  logic        xfer;
  logic        load;
  logic [7:0]  sh_byte;
  logic        sh_last;
  logic [7:0]  frame_byte;
  logic        overflow_q;
  logic [15:0] frame_cnt_q;

  assign rise = done & ~done_q;
  assign xfer = out_valid & out_ready;
  assign load = (state_q == IDLE) & rise;

  byte_shifter #(
    .WIDTH  (NONCE_W + HASH_W),
    .NBYTES (FRAME_LEN)
  ) u_byte_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data ({golden_nonce, hashed}),
    .shift     (xfer),
    .top_byte  (sh_byte),
    .last      (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = SEND;
      SEND:    if (xfer && sh_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'h00;
    busy      = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_last  = sh_last;
      out_data  = frame_byte;
      busy      = 1'b1;
    end
  end

  // A rise while a frame is in flight (including its last cycle) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= done;
      if ((state_q == SEND) && rise) overflow_q <= 1'b1;
      if (xfer && sh_last) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

`ifdef RESULT_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else if (load) begin
      csum_q <= 8'h00;
    end else if (xfer && !sh_last) begin
      csum_q <= csum_q ^ sh_byte;
    end
  end

  assign frame_byte = sh_last ? csum_q : sh_byte;
`else
  assign frame_byte = sh_byte;
`endif

  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;

endmodule
